dsi_lane_hs_ctrl: RTL and testbench
===================================

DSI_LANE_HS_CTRL -- requirements
Module: dsi_lane_hs_ctrl

Interface
REQ-001 Parameter T_LPX, 2, LP-01 duration in clk cycles (1..255).
REQ-002 Parameter T_HS_PREPARE, 2, LP-00 duration before HS-zero (1..255).
REQ-003 Parameter T_HS_ZERO, 4, HS-zero byte count (1..255).
REQ-004 Parameter T_HS_TRAIL, 3, trail byte count (1..255).
REQ-005 Parameter T_HS_EXIT, 2, LP-11 hold after trail, before accepting a new burst (1..255).
REQ-006 clk  in  1  byte clock, single clock domain.
REQ-007 rst  in  1  synchronous reset, active-high.
REQ-008 mode_lp  in  1  burst mode; 0 = HS, 1 = LP. Sampled only on the start_rqst cycle.
REQ-009 start_rqst  in  1  one-cycle burst start from the upstream FIFO bridge.
REQ-010 fin_rqst  in  1  one-cycle burst end; byte on inp_data in that cycle is the last byte.
REQ-011 inp_data  in  8  registered byte from the upstream bridge.
REQ-012 data_rqst  out  1  combinational; 1 = lane accepts inp_data this cycle / ready for start.
REQ-013 lp_p, lp_n  out  1 each  LP line levels.
REQ-014 hs_en  out  1  HS driver enable.
REQ-015 hs_byte  out  8  byte to HS serializer.
REQ-016 hs_valid  out  1  hs_byte valid.
REQ-017 busy  out  1  state != IDLE.
REQ-018 lp_rqst_err  out  1  one-cycle pulse when an LP burst is requested.

Function
REQ-019 States: IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT, DISCARD; Moore outputs from state, except hs_byte in DATA, which equals inp_data.
REQ-020 IDLE: lp=11, hs_en=0, hs_valid=0, data_rqst=1; start_rqst with mode_lp=0 -> LPX; with mode_lp=1 -> DISCARD plus lp_rqst_err=1 next cycle.
REQ-021 LPX: lp=01 for T_LPX cycles -> PREP.
REQ-022 PREP: lp=00, hs_en=1, hs_valid=0, for T_HS_PREPARE cycles -> ZERO.
REQ-023 ZERO: lp=00, hs_en=1, hs_valid=1, hs_byte=0x00, for T_HS_ZERO cycles -> SYNC.
REQ-024 SYNC: hs_byte=0xB8, hs_valid=1, one cycle -> DATA.
REQ-025 DATA: data_rqst=1, hs_valid=1, hs_byte=inp_data; last_bit register <= inp_data[7] every cycle; leave DATA -> TRAIL after the cycle where fin_rqst=1 or fin_pending=1.
REQ-026 data_rqst=0 in LPX, PREP, ZERO, SYNC, TRAIL and EXIT; upstream holds inp_data stable.
REQ-027 fin_rqst arriving in LPX/PREP/ZERO/SYNC sets fin_pending; DATA then lasts exactly one cycle. fin_pending clears on TRAIL entry.
REQ-028 TRAIL: hs_valid=1, hs_byte = {8{~last_bit}}, for T_HS_TRAIL cycles -> EXIT.
REQ-029 EXIT: lp=11, hs_en=0, hs_valid=0, for T_HS_EXIT cycles -> IDLE.
REQ-030 DISCARD: lp=11, hs_en=0, data_rqst=1, bytes dropped; fin_rqst -> IDLE next cycle.
REQ-031 start_rqst outside IDLE is ignored; fin_rqst in IDLE or EXIT is ignored.
REQ-032 Phase counter is 8 bits; it loads the state duration on state entry and counts to zero with no wrap.

Reset
REQ-033 rst=1 in any state forces IDLE on the next edge: lp=11, hs_en=0, hs_valid=0, hs_byte=0x00, busy=0, lp_rqst_err=0, fin_pending=0, last_bit=0, counter=0.
REQ-034 Reset mid-burst drops HS immediately without a trail; data_rqst=1 from the first cycle after rst deasserts.

Verification (default parameters; start_rqst at cycle 0)
REQ-035 Bench drives a 3-byte HS burst 0x11,0x22,0x93 with fin_rqst at cycle 12 -> lp=01 at cycles 1-2, lp=00 at 3-4, hs_byte 0x00 at 5-8, 0xB8 at 9, 0x11/0x22/0x93 at 10-12, 0x00 at 13-15, lp=11 at 16-17, IDLE with data_rqst=1 at 18.
REQ-036 Bench drives a 1-byte burst 0x7F with fin_rqst at cycle 1 -> one DATA cycle at 10 with 0x7F, trail 0xFF at 11-13, IDLE at 16.
REQ-037 Bench drives start_rqst with mode_lp=1, then 4 bytes, then fin_rqst at cycle 5 -> lp_rqst_err=1 at cycle 1 only, lp stays 11, hs_en=0 throughout, IDLE at cycle 6.
REQ-038 Bench asserts rst at cycle 11 of the REQ-035 burst -> lp=11, hs_en=0, hs_valid=0 at cycle 12, with no trail bytes.
REQ-039 Bench repeats start_rqst at cycles 3 and 17 of the REQ-035 burst -> both ignored, with timing identical to REQ-035.
REQ-040 Bench sets T_LPX=1, T_HS_ZERO=1, T_HS_TRAIL=1, T_HS_EXIT=1 -> each phase lasts exactly one cycle, with no counter wrap.

Source files
------------

// File: rtl/dsi_lane_hs_ctrl_if.sv
// Upstream bridge <-> DSI lane controller signal bundle.
// The bridge side is the master; the lane controller is the slave.
interface dsi_lane_hs_ctrl_if;
    logic       mode_lp;
    logic       start_rqst;
    logic       fin_rqst;
    logic [7:0] inp_data;
    logic       data_rqst;
    logic       lp_p;
    logic       lp_n;
    logic       hs_en;
    logic [7:0] hs_byte;
    logic       hs_valid;
    logic       busy;
    logic       lp_rqst_err;

    modport master (
        output mode_lp, start_rqst, fin_rqst, inp_data,
        input  data_rqst, lp_p, lp_n, hs_en, hs_byte, hs_valid, busy, lp_rqst_err
    );

    modport slave (
        input  mode_lp, start_rqst, fin_rqst, inp_data,
        output data_rqst, lp_p, lp_n, hs_en, hs_byte, hs_valid, busy, lp_rqst_err
    );
endinterface

// File: rtl/dsi_lane_hs_ctrl.sv
// DSI data lane high-speed burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero ->
// sync -> payload -> trail -> LP-11, with LP-mode requests discarded and flagged.
module dsi_lane_hs_ctrl #(
    parameter int unsigned T_LPX        = 2,
    parameter int unsigned T_HS_PREPARE = 2,
    parameter int unsigned T_HS_ZERO    = 4,
    parameter int unsigned T_HS_TRAIL   = 3,
    parameter int unsigned T_HS_EXIT    = 2
) (
    input  logic               clk,
    input  logic               rst,
    dsi_lane_hs_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned BYTE_W    = 8;
    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hB8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LPX,
        S_PREP,
        S_ZERO,
        S_SYNC,
        S_DATA,
        S_TRAIL,
        S_EXIT,
        S_DISCARD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fin_pending_q, fin_pending_d;
    logic               last_bit_q, last_bit_d;
    logic               lp_rqst_err_q, lp_rqst_err_d;
    logic               phase_done;

    logic               lp_p_c, lp_n_c, hs_en_c, hs_valid_c, data_rqst_c, busy_c;
    logic [BYTE_W-1:0]  hs_byte_c;

    // Counter holds remaining cycles minus one, so a phase ends when it reads zero.
    function automatic logic [CNT_W-1:0] phase_load(input state_t s);
        case (s)
            S_LPX:   phase_load = CNT_W'(T_LPX - 1);
            S_PREP:  phase_load = CNT_W'(T_HS_PREPARE - 1);
            S_ZERO:  phase_load = CNT_W'(T_HS_ZERO - 1);
            S_TRAIL: phase_load = CNT_W'(T_HS_TRAIL - 1);
            S_EXIT:  phase_load = CNT_W'(T_HS_EXIT - 1);
            default: phase_load = '0;
        endcase
    endfunction

    assign phase_done = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            fin_pending_q <= 1'b0;
            last_bit_q    <= 1'b0;
            lp_rqst_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fin_pending_q <= fin_pending_d;
            last_bit_q    <= last_bit_d;
            lp_rqst_err_q <= lp_rqst_err_d;
        end
    end

    // Next-state, phase counter and burst-end bookkeeping.
    always_comb begin
        state_d       = state_q;
        cnt_d         = phase_done ? cnt_q : cnt_q - CNT_W'(1);
        fin_pending_d = fin_pending_q;
        last_bit_d    = last_bit_q;
        lp_rqst_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start_rqst) begin
                    if (bus.mode_lp) begin
                        state_d       = S_DISCARD;
                        lp_rqst_err_d = 1'b1;
                    end else begin
                        state_d = S_LPX;
                    end
                end
            end
            S_LPX:   if (phase_done) state_d = S_PREP;
            S_PREP:  if (phase_done) state_d = S_ZERO;
            S_ZERO:  if (phase_done) state_d = S_SYNC;
            S_SYNC:  state_d = S_DATA;
            S_DATA: begin
                last_bit_d = bus.inp_data[BYTE_W-1];
                if (bus.fin_rqst || fin_pending_q) begin
                    state_d       = S_TRAIL;
                    fin_pending_d = 1'b0;
                end
            end
            S_TRAIL:   if (phase_done) state_d = S_EXIT;
            S_EXIT:    if (phase_done) state_d = S_IDLE;
            S_DISCARD: if (bus.fin_rqst) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // An early burst end is remembered until the single payload cycle.
        if ((state_q inside {S_LPX, S_PREP, S_ZERO, S_SYNC}) && bus.fin_rqst) begin
            fin_pending_d = 1'b1;
        end

        if (state_d != state_q) begin
            cnt_d = phase_load(state_d);
        end
    end

    // Moore line/driver decode; only the payload byte passes through from the bridge.
    always_comb begin
        lp_p_c      = 1'b1;
        lp_n_c      = 1'b1;
        hs_en_c     = 1'b0;
        hs_valid_c  = 1'b0;
        hs_byte_c   = '0;
        data_rqst_c = 1'b0;
        busy_c      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE:    data_rqst_c = 1'b1;
            S_LPX:     lp_p_c = 1'b0;
            S_PREP: begin
                lp_p_c  = 1'b0;
                lp_n_c  = 1'b0;
                hs_en_c = 1'b1;
            end
            S_ZERO: begin
                lp_p_c     = 1'b0;
                lp_n_c     = 1'b0;
                hs_en_c    = 1'b1;
                hs_valid_c = 1'b1;
            end
            S_SYNC: begin
                lp_p_c     = 1'b0;
                lp_n_c     = 1'b0;
                hs_en_c    = 1'b1;
                hs_valid_c = 1'b1;
                hs_byte_c  = SYNC_BYTE;
            end
            S_DATA: begin
                lp_p_c      = 1'b0;
                lp_n_c      = 1'b0;
                hs_en_c     = 1'b1;
                hs_valid_c  = 1'b1;
                hs_byte_c   = bus.inp_data;
                data_rqst_c = 1'b1;
            end
            S_TRAIL: begin
                lp_p_c     = 1'b0;
                lp_n_c     = 1'b0;
                hs_en_c    = 1'b1;
                hs_valid_c = 1'b1;
                hs_byte_c  = {BYTE_W{~last_bit_q}};
            end
            S_DISCARD: data_rqst_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.lp_p        = lp_p_c;
    assign bus.lp_n        = lp_n_c;
    assign bus.hs_en       = hs_en_c;
    assign bus.hs_valid    = hs_valid_c;
    assign bus.hs_byte     = hs_byte_c;
    assign bus.data_rqst   = data_rqst_c;
    assign bus.busy        = busy_c;
    assign bus.lp_rqst_err = lp_rqst_err_q;

endmodule

// File: tb/tb_dsi_lane_hs_ctrl.sv
// Self-checking bench for dsi_lane_hs_ctrl: directed vector table, hand sequences,
// and randomized bursts checked against a phase-boundary reference model.
module tb_dsi_lane_hs_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsi_lane_hs_ctrl_if bus_a ();
    dsi_lane_hs_ctrl_if bus_b ();

    dsi_lane_hs_ctrl u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dsi_lane_hs_ctrl #(
        .T_LPX        (1),
        .T_HS_PREPARE (2),
        .T_HS_ZERO    (1),
        .T_HS_TRAIL   (1),
        .T_HS_EXIT    (1)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic [1:0] lp;
        logic       hs_en;
        logic       hs_valid;
        logic [7:0] hs_byte;
        logic       dr;
        logic       busy;
        logic       err;
    } exp_t;

    typedef struct {
        logic       st;
        logic       fin;
        logic       mode;
        logic [7:0] din;
        exp_t       e;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [7:0] bq[$];

    function automatic exp_t mk_exp(input logic [1:0] lp, input logic en, input logic v,
                                    input logic [7:0] b, input logic dr, input logic bz,
                                    input logic er);
        exp_t e;
        e.lp = lp; e.hs_en = en; e.hs_valid = v; e.hs_byte = b;
        e.dr = dr; e.busy = bz; e.err = er;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic st, input logic fin, input logic [7:0] din,
                                    input exp_t e);
        vec_t v;
        v.st = st; v.fin = fin; v.mode = 1'b0; v.din = din; v.e = e;
        return v;
    endfunction

    task automatic drive(input logic st, input logic fin, input logic mode, input logic [7:0] d);
        bus_a.start_rqst = st; bus_a.fin_rqst = fin; bus_a.mode_lp = mode; bus_a.inp_data = d;
        bus_b.start_rqst = st; bus_b.fin_rqst = fin; bus_b.mode_lp = mode; bus_b.inp_data = d;
    endtask

    function automatic exp_t sample(input bit sel);
        exp_t a;
        if (sel) a = mk_exp({bus_b.lp_p, bus_b.lp_n}, bus_b.hs_en, bus_b.hs_valid, bus_b.hs_byte,
                            bus_b.data_rqst, bus_b.busy, bus_b.lp_rqst_err);
        else     a = mk_exp({bus_a.lp_p, bus_a.lp_n}, bus_a.hs_en, bus_a.hs_valid, bus_a.hs_byte,
                            bus_a.data_rqst, bus_a.busy, bus_a.lp_rqst_err);
        return a;
    endfunction

    task automatic compare(input string name, input int k, input exp_t e, input exp_t a);
        checks++;
        if ({a.lp, a.hs_en, a.hs_valid, a.dr, a.busy, a.err} !==
            {e.lp, e.hs_en, e.hs_valid, e.dr, e.busy, e.err}) begin
            errors++;
            $display("FAIL %s cycle %0d: got lp=%b hs_en=%b hs_valid=%b data_rqst=%b busy=%b err=%b, expected lp=%b hs_en=%b hs_valid=%b data_rqst=%b busy=%b err=%b",
                     name, k, a.lp, a.hs_en, a.hs_valid, a.dr, a.busy, a.err,
                     e.lp, e.hs_en, e.hs_valid, e.dr, e.busy, e.err);
        end
        if (e.hs_valid || !e.busy) begin
            checks++;
            if (a.hs_byte !== e.hs_byte) begin
                errors++;
                $display("FAIL %s cycle %0d: hs_byte got %02h expected %02h", name, k, a.hs_byte, e.hs_byte);
            end
        end
    endtask

    // Cycle index at which the lane is back in IDLE for an HS burst ending at fin cycle f.
    function automatic int hs_end(input int tl, input int tp, input int tz, input int tt,
                                  input int te, input int f);
        int b5, de;
        b5 = 1 + tl + tp + tz + 1;
        de = (f < b5) ? b5 : f;
        return de + 1 + tt + te;
    endfunction

    // Reference: expected outputs at cycle k (start at cycle 0) from the phase boundaries.
    function automatic exp_t model_hs(input int k, input int tl, input int tp, input int tz,
                                      input int tt, input int te, input int f,
                                      input logic [7:0] dk, input logic [7:0] dlast);
        int b2, b3, b4, b5, de, b6, b7, b8;
        exp_t e;
        b2 = 1 + tl; b3 = b2 + tp; b4 = b3 + tz; b5 = b4 + 1;
        de = (f < b5) ? b5 : f;
        b6 = de + 1; b7 = b6 + tt; b8 = b7 + te;
        e = mk_exp(2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        if (k >= 1 && k < b8) begin e.busy = 1'b1; e.dr = 1'b0; end
        if (k >= 1 && k < b2) e.lp = 2'b01;
        if (k >= b2 && k < b7) begin e.lp = 2'b00; e.hs_en = 1'b1; end
        if (k >= b3 && k < b7) e.hs_valid = 1'b1;
        if (k == b4) e.hs_byte = 8'hB8;
        if (k >= b5 && k <= de) begin e.hs_byte = dk; e.dr = 1'b1; end
        if (k >= b6 && k < b7) e.hs_byte = {8{~dlast[7]}};
        return e;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        compare("reset_a", 0, mk_exp(2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0), sample(1'b0));
        compare("reset_b", 0, mk_exp(2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0), sample(1'b1));
    endtask

    // HS burst: payload bytes from bq, fin at cycle f, extra ignored starts at xs1/xs2.
    task automatic run_hs(input string name, input bit sel, input int tl, input int tp,
                          input int tz, input int tt, input int te, input int f,
                          input int xs1, input int xs2, input bit rnd);
        int b5, b7, b8, de;
        logic [7:0] d[64];
        logic st, fin, mode;
        b5 = 1 + tl + tp + tz + 1;
        de = (f < b5) ? b5 : f;
        b8 = hs_end(tl, tp, tz, tt, te, f);
        b7 = b8 - te;
        for (int k = 0; k < b8 + 2; k++) begin
            if (k >= b5 && (k - b5) < bq.size()) d[k] = bq[k - b5];
            else if (k == 0) d[k] = bq[0];
            else d[k] = d[k - 1];
        end
        for (int k = 0; k < b8 + 2; k++) begin
            st   = (k == 0) || (k == xs1) || (k == xs2);
            fin  = (k == f) || (rnd && k >= b7 && k < b8 && $urandom_range(0, 1) == 1);
            mode = (k == 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            @(posedge clk); #1;
            drive(st, fin, mode, d[k]);
            @(negedge clk);
            compare(name, k, model_hs(k, tl, tp, tz, tt, te, f, d[k], d[de]), sample(sel));
        end
    endtask

    // LP request: discarded until fin at cycle f, error pulse on cycle 1 only.
    task automatic run_lp(input string name, input int f, input int xs);
        exp_t e;
        for (int k = 0; k < f + 3; k++) begin
            @(posedge clk); #1;
            drive((k == 0) || (k == xs), (k == f), (k == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                  8'($urandom));
            @(negedge clk);
            if (k >= 1 && k <= f) e = mk_exp(2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, (k == 1));
            else                  e = mk_exp(2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            compare(name, k, e, sample(1'b0));
        end
    endtask

    vec_t tbl[19];
    exp_t e_idle, e_lpx, e_prep, e_zero, e_trail0, e_exit;

    initial begin
        int f, n, b8, xs;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        e_idle   = mk_exp(2'b11, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        e_lpx    = mk_exp(2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        e_prep   = mk_exp(2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        e_zero   = mk_exp(2'b00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        e_trail0 = e_zero;
        e_exit   = mk_exp(2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tbl[0]  = mk_vec(1'b1, 1'b0, 8'h11, e_idle);
        tbl[1]  = mk_vec(1'b0, 1'b0, 8'h11, e_lpx);
        tbl[2]  = mk_vec(1'b0, 1'b0, 8'h11, e_lpx);
        tbl[3]  = mk_vec(1'b0, 1'b0, 8'h11, e_prep);
        tbl[4]  = mk_vec(1'b0, 1'b0, 8'h11, e_prep);
        for (int i = 5; i <= 8; i++) tbl[i] = mk_vec(1'b0, 1'b0, 8'h11, e_zero);
        tbl[9]  = mk_vec(1'b0, 1'b0, 8'h11, mk_exp(2'b00, 1'b1, 1'b1, 8'hB8, 1'b0, 1'b1, 1'b0));
        tbl[10] = mk_vec(1'b0, 1'b0, 8'h11, mk_exp(2'b00, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0));
        tbl[11] = mk_vec(1'b0, 1'b0, 8'h22, mk_exp(2'b00, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0));
        tbl[12] = mk_vec(1'b0, 1'b1, 8'h93, mk_exp(2'b00, 1'b1, 1'b1, 8'h93, 1'b1, 1'b1, 1'b0));
        for (int i = 13; i <= 15; i++) tbl[i] = mk_vec(1'b0, 1'b0, 8'h93, e_trail0);
        tbl[16] = mk_vec(1'b0, 1'b0, 8'h93, e_exit);
        tbl[17] = mk_vec(1'b0, 1'b0, 8'h93, e_exit);
        tbl[18] = mk_vec(1'b0, 1'b0, 8'h93, e_idle);

        // Three-byte HS burst from the directed vector table.
        do_reset();
        for (int k = 0; k < 19; k++) begin
            @(posedge clk); #1;
            drive(tbl[k].st, tbl[k].fin, tbl[k].mode, tbl[k].din);
            @(negedge clk);
            compare("table_3byte", k, tbl[k].e, sample(1'b0));
        end

        // Reset in the middle of the payload: no trail afterwards.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            rst = (k == 11);
            drive(tbl[k].st, tbl[k].fin, tbl[k].mode, tbl[k].din);
            @(negedge clk);
            if (k <= 11) compare("mid_reset", k, tbl[k].e, sample(1'b0));
            else         compare("mid_reset", k, e_idle, sample(1'b0));
        end

        // One-byte burst with early fin.
        do_reset();
        bq = {8'h7F};
        run_hs("one_byte", 1'b0, 2, 2, 4, 3, 2, 1, -1, -1, 1'b0);

        // Repeated starts while busy are ignored.
        do_reset();
        bq = {8'h11, 8'h22, 8'h93};
        run_hs("repeat_start", 1'b0, 2, 2, 4, 3, 2, 12, 3, 17, 1'b0);

        // LP-mode request discarded.
        do_reset();
        run_lp("lp_discard", 5, -1);

        // Minimum phase lengths.
        do_reset();
        bq = {8'hA5};
        run_hs("fast_early_fin", 1'b1, 1, 2, 1, 1, 1, 1, -1, -1, 1'b0);
        do_reset();
        bq = {8'h01, 8'h82};
        run_hs("fast_two_byte", 1'b1, 1, 2, 1, 1, 1, 7, -1, -1, 1'b0);

        // Randomized HS bursts on both parameter sets.
        for (int it = 0; it < 30; it++) begin
            bit sel;
            int tl, tz, tt, te;
            sel = (it % 3 == 2);
            tl = sel ? 1 : 2; tz = sel ? 1 : 4; tt = sel ? 1 : 3; te = sel ? 1 : 2;
            n = $urandom_range(1, 6);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            f = $urandom_range(1, 1 + tl + 2 + tz + 1 + n - 1);
            b8 = hs_end(tl, 2, tz, tt, te, f);
            xs = $urandom_range(1, b8 - 1);
            do_reset();
            run_hs("rand_hs", sel, tl, 2, tz, tt, te, f, xs, -1, 1'b1);
        end

        // Randomized LP requests.
        for (int it = 0; it < 10; it++) begin
            f = $urandom_range(1, 8);
            xs = $urandom_range(1, f);
            do_reset();
            run_lp("rand_lp", f, xs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
